lifo_burst_reader: RTL and testbench

- Downstream drain stage for the synchronous LIFO. It consumes the LIFO's read side: rdreq out, q, empty and usedw in.
- On a command it pops a burst of N words and presents them on a valid/ready stream, marking the final word with last.
- It absorbs the LIFO's 1-cycle read latency with a 3-entry output buffer, so it never loses a word under backpressure.
- It never pops in a cycle where the LIFO is being written. The LIFO gives writes priority, so a pop in that cycle would return data without decrementing.

---
 rtl/lifo_burst_reader.sv | 206 ++++++++++++++++++++
 tb/tb_lifo_burst_reader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_burst_reader.sv
// -----------------------------------------------------------------------------
// lifo_burst_reader
//
// Drain stage that sits on the read side of a synchronous LIFO. On a start
// command it pops a burst of words and presents them on a valid/ready stream,
// tagging the final word with m_last_o.
//
// The LIFO has a one-cycle read latency. A 3-entry output buffer absorbs that
// latency, so no word is lost under backpressure. A pop is only issued when the
// buffer has room for every word already requested.
//
// Ports
//   clk_i, srst_i    clock and synchronous active-high reset
//   start_i, len_i   burst command; len_i==0 means "everything currently stored"
//   busy_o, done_o   burst in progress / one-cycle completion pulse
//   lifo_*           LIFO read interface plus a copy of its write strobe
//   m_*              output stream (valid/ready, last marks the end of a burst)
// -----------------------------------------------------------------------------
module lifo_burst_reader #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              start_i,
    input  logic [AWIDTH:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              lifo_rdreq_o,
    input  logic [DWIDTH-1:0] lifo_q_i,
    input  logic              lifo_empty_i,
    input  logic [AWIDTH:0]   lifo_usedw_i,
    input  logic              lifo_wrreq_i,
    output logic [DWIDTH-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              m_last_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [AWIDTH:0] LEN_ZERO = '0;
    localparam logic [AWIDTH:0] LEN_ONE  = {{AWIDTH{1'b0}}, 1'b1};

    // Control state
    state_t          r_state;
    logic [AWIDTH:0] r_remaining;
    logic            r_busy;
    logic            r_done;
    logic            r_inflight;       // a pop was issued last cycle
    logic            r_inflight_last;  // ...and it was the final word of the burst

    // Output buffer: entry 0 is the head and drives the stream directly
    logic [DWIDTH-1:0] r_buf_data [3];
    logic [2:0]        r_buf_last;
    logic [1:0]        r_buf_cnt;

    logic              w_room;
    logic              w_rdreq;
    logic              w_pop;
    logic              w_push;
    logic [1:0]        w_wr_idx;
    logic [AWIDTH:0]   w_start_len;
    logic [DWIDTH-1:0] w_data_next [3];
    logic [2:0]        w_last_next;

    // Room is counted against words already in flight, so the buffer can
    // never overflow even when the consumer stalls forever.
    assign w_room = ({1'b0, r_buf_cnt} + {2'b00, r_inflight}) < 3'd3;

    // A pop during a LIFO write would return data without decrementing the
    // LIFO, so those cycles are skipped. Reset is included so that no pop
    // escapes while the state is being cleared.
    assign w_rdreq = !srst_i
                   && (r_state == S_DRAIN)
                   && !lifo_empty_i
                   && !lifo_wrreq_i
                   && (r_remaining != LEN_ZERO)
                   && w_room;

    assign w_start_len = (len_i == LEN_ZERO) ? lifo_usedw_i : len_i;

    assign w_push   = r_inflight;
    assign w_pop    = m_valid_o && m_ready_i;
    // Slot for the incoming word after any simultaneous head removal
    assign w_wr_idx = r_buf_cnt - {1'b0, w_pop};

    assign lifo_rdreq_o = w_rdreq;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign m_valid_o    = (r_buf_cnt != 2'd0);
    assign m_data_o     = r_buf_data[0];
    assign m_last_o     = r_buf_last[0] && m_valid_o;

    // -------------------------------------------------------------------------
    // Burst control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state         <= S_IDLE;
            r_remaining     <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_done          <= 1'b0;
            r_inflight      <= w_rdreq;
            r_inflight_last <= w_rdreq && (r_remaining == LEN_ONE);

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (w_start_len == LEN_ZERO) begin
                            // Nothing to drain: complete immediately
                            r_done <= 1'b1;
                        end else begin
                            r_remaining <= w_start_len;
                            r_busy      <= 1'b1;
                            r_state     <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    // An empty LIFO simply stalls here until new words arrive
                    if (w_rdreq) begin
                        r_remaining <= r_remaining - LEN_ONE;
                        if (r_remaining == LEN_ONE) begin
                            r_state <= S_FLUSH;
                        end
                    end
                end

                S_FLUSH: begin
                    if (w_pop && m_last_o) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output buffer next state: shift toward the head on a handshake, then
    // drop the returning LIFO word into the first free slot.
    // -------------------------------------------------------------------------
    always_comb begin
        w_data_next = r_buf_data;
        w_last_next = r_buf_last;

        if (w_pop) begin
            w_data_next[0] = r_buf_data[1];
            w_data_next[1] = r_buf_data[2];
            w_data_next[2] = '0;
            w_last_next    = {1'b0, r_buf_last[2:1]};
        end

        if (w_push) begin
            case (w_wr_idx)
                2'd0: begin
                    w_data_next[0] = lifo_q_i;
                    w_last_next[0] = r_inflight_last;
                end
                2'd1: begin
                    w_data_next[1] = lifo_q_i;
                    w_last_next[1] = r_inflight_last;
                end
                2'd2: begin
                    w_data_next[2] = lifo_q_i;
                    w_last_next[2] = r_inflight_last;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_buf_cnt  <= 2'd0;
            r_buf_last <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                r_buf_data[i] <= '0;
            end
        end else begin
            r_buf_cnt  <= r_buf_cnt + {1'b0, w_push} - {1'b0, w_pop};
            r_buf_last <= w_last_next;
            for (int i = 0; i < 3; i++) begin
                r_buf_data[i] <= w_data_next[i];
            end
        end
    end

endmodule

// File: tb/tb_lifo_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_lifo_burst_reader
//
// Directed bench for lifo_burst_reader. A small behavioural LIFO (writes take
// priority over pops, read data registered) feeds the reader. Inputs change
// just after the falling edge; outputs are sampled 2 time units later.
// -----------------------------------------------------------------------------
module tb_lifo_burst_reader;

    localparam int DWIDTH = 8;
    localparam int AWIDTH = 4;

    logic              clk = 1'b0;
    logic              srst_i;
    logic              start_i;
    logic [AWIDTH:0]   len_i;
    logic              busy_o;
    logic              done_o;
    logic              lifo_rdreq_o;
    logic [DWIDTH-1:0] lifo_q_i;
    logic              lifo_empty_i;
    logic [AWIDTH:0]   lifo_usedw_i;
    logic              lifo_wrreq_i;
    logic [DWIDTH-1:0] m_data_o;
    logic              m_valid_o;
    logic              m_ready_i;
    logic              m_last_o;

    always #5 clk = ~clk;

    lifo_burst_reader #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
        .clk_i        (clk),
        .srst_i       (srst_i),
        .start_i      (start_i),
        .len_i        (len_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .lifo_rdreq_o (lifo_rdreq_o),
        .lifo_q_i     (lifo_q_i),
        .lifo_empty_i (lifo_empty_i),
        .lifo_usedw_i (lifo_usedw_i),
        .lifo_wrreq_i (lifo_wrreq_i),
        .m_data_o     (m_data_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_last_o     (m_last_o)
    );

    // ---------------- behavioural LIFO ----------------
    logic              lifo_rst;
    logic [DWIDTH-1:0] lifo_wdata;
    logic [DWIDTH-1:0] lmem [16];
    logic [4:0]        l_usedw;
    logic [DWIDTH-1:0] popped [$];

    assign lifo_usedw_i = l_usedw;
    assign lifo_empty_i = (l_usedw == 5'd0);

    always @(posedge clk) begin
        logic [3:0] top;
        top = 4'(l_usedw - 5'd1);
        if (lifo_rst) begin
            l_usedw  <= 5'd0;
            lifo_q_i <= '0;
        end else if (lifo_wrreq_i) begin
            if (l_usedw < 5'd16) begin
                lmem[l_usedw[3:0]] <= lifo_wdata;
                l_usedw            <= l_usedw + 5'd1;
            end
        end else if (lifo_rdreq_o && l_usedw != 5'd0) begin
            lifo_q_i <= lmem[top];
            l_usedw  <= l_usedw - 5'd1;
            popped.push_back(lmem[top]);
        end
    end

    // ---------------- bookkeeping ----------------
    int vectors     = 0;
    int miscompares = 0;
    int cyc_n       = 0;
    int rdy_mode    = 0;   // 0: ready=1, 1: pattern 1,0,0,1, 2: ready=0
    bit wr_mode     = 0;   // alternate-cycle LIFO writes

    logic [DWIDTH-1:0] got_data [$];
    logic              got_last [$];
    logic [DWIDTH-1:0] exp_data [$];
    int first_rd, first_vld, first_hs, last_hs, last_word_cyc, done_cyc;
    bit done_seen;
    bit stall_prev;
    logic [DWIDTH-1:0] stall_data;
    logic              stall_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_capture();
        got_data.delete();
        got_last.delete();
        exp_data.delete();
        first_rd = -1; first_vld = -1; first_hs = -1; last_hs = -1;
        last_word_cyc = -1; done_cyc = -1; done_seen = 0; stall_prev = 0;
    endtask

    // One clock cycle: apply per-cycle stimulus, sample, run invariants.
    task automatic cyc();
        if (rdy_mode == 0)      m_ready_i = 1'b1;
        else if (rdy_mode == 1) m_ready_i = ((cyc_n % 4) == 0) || ((cyc_n % 4) == 3);
        else                    m_ready_i = 1'b0;
        if (wr_mode) begin
            lifo_wrreq_i = ((cyc_n % 2) == 0);
            lifo_wdata   = 8'(8'hC0 + cyc_n);
        end
        #2;
        if (lifo_wrreq_i)
            check("no_pop_during_write", {31'd0, lifo_rdreq_o}, 32'd0);
        if (lifo_rdreq_o)
            check("pop_room", {31'd0, ({1'b0, dut.r_buf_cnt} + {2'b00, dut.r_inflight}) < 3'd3}, 32'd1);
        if (stall_prev) begin
            check("stall_valid", {31'd0, m_valid_o}, 32'd1);
            check("stall_data", {24'd0, m_data_o}, {24'd0, stall_data});
            check("stall_last", {31'd0, m_last_o}, {31'd0, stall_last});
        end
        if (lifo_rdreq_o && first_rd < 0) first_rd = cyc_n;
        if (m_valid_o && first_vld < 0)   first_vld = cyc_n;
        if (m_valid_o && m_ready_i) begin
            got_data.push_back(m_data_o);
            got_last.push_back(m_last_o);
            if (first_hs < 0) first_hs = cyc_n;
            last_hs = cyc_n;
            if (m_last_o) last_word_cyc = cyc_n;
        end
        if (done_o) begin
            done_seen = 1;
            done_cyc  = cyc_n;
        end
        stall_prev = m_valid_o && !m_ready_i && !srst_i;
        stall_data = m_data_o;
        stall_last = m_last_o;
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic lifo_write(input logic [DWIDTH-1:0] d);
        lifo_wrreq_i = 1'b1;
        lifo_wdata   = d;
        cyc();
        lifo_wrreq_i = 1'b0;
    endtask

    task automatic start_burst(input logic [AWIDTH:0] len);
        start_i = 1'b1;
        len_i   = len;
        cyc();
        start_i = 1'b0;
        len_i   = '0;
    endtask

    task automatic do_reset();
        srst_i   = 1'b1;
        lifo_rst = 1'b1;
        cyc();
        srst_i   = 1'b0;
        lifo_rst = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        for (int i = 0; i < budget && !done_seen; i++) cyc();
        check("done_within_budget", {31'd0, done_seen}, 32'd1);
    endtask

    // Compare captured stream with exp_data; last only on the final word.
    task automatic check_stream(input string tag);
        int n;
        check({tag, "_count"}, got_data.size(), exp_data.size());
        n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, {24'd0, got_data[i]}, {24'd0, exp_data[i]});
            check({tag, "_last"}, {31'd0, got_last[i]}, (i == exp_data.size() - 1) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        srst_i = 1'b1; lifo_rst = 1'b1; start_i = 1'b0; len_i = '0;
        lifo_wrreq_i = 1'b0; lifo_wdata = '0; m_ready_i = 1'b1;
        clear_capture();
        @(negedge clk);
        cyc(); cyc();
        srst_i = 1'b0; lifo_rst = 1'b0;

        // ---- reset state ----
        check("rst_busy",  {31'd0, busy_o}, 32'd0);
        check("rst_done",  {31'd0, done_o}, 32'd0);
        check("rst_rdreq", {31'd0, lifo_rdreq_o}, 32'd0);
        check("rst_valid", {31'd0, m_valid_o}, 32'd0);
        check("rst_last",  {31'd0, m_last_o}, 32'd0);
        check("rst_data",  {24'd0, m_data_o}, 32'd0);

        // ---- basic burst: 4 words, pop 3 ----
        lifo_write(8'h11); lifo_write(8'h22); lifo_write(8'h33); lifo_write(8'h44);
        clear_capture();
        start_burst(5'd3);
        check("basic_busy", {31'd0, busy_o}, 32'd1);
        run_until_done(40);
        exp_data = '{8'h44, 8'h33, 8'h22};
        check_stream("basic");
        check("basic_latency", first_vld - first_rd, 32'd2);
        check("basic_done_after_last", done_cyc - last_word_cyc, 32'd1);
        check("basic_done_pulse", {31'd0, done_o}, 32'd0);
        check("basic_idle", {31'd0, busy_o}, 32'd0);
        check("basic_usedw", {27'd0, lifo_usedw_i}, 32'd1);

        // ---- zero-length on empty LIFO ----
        do_reset();
        clear_capture();
        start_burst(5'd0);
        check("len0_done", {31'd0, done_o}, 32'd1);
        check("len0_busy", {31'd0, busy_o}, 32'd0);
        cyc();
        check("len0_done_pulse", {31'd0, done_o}, 32'd0);

        // ---- drain-all: 16 words ----
        for (int i = 0; i < 16; i++) lifo_write(8'(i));
        check("full_usedw", {27'd0, lifo_usedw_i}, 32'd16);
        clear_capture();
        start_burst(5'd0);
        run_until_done(60);
        for (int i = 15; i >= 0; i--) exp_data.push_back(8'(i));
        check_stream("drain_all");
        check("drain_all_b2b", last_hs - first_hs, 32'd15);
        check("drain_all_empty", {31'd0, lifo_empty_i}, 32'd1);

        // ---- backpressure: ready 1,0,0,1 ----
        do_reset();
        for (int i = 0; i < 8; i++) lifo_write(8'(8'h80 + i));
        clear_capture();
        rdy_mode = 1;
        start_burst(5'd8);
        run_until_done(100);
        rdy_mode = 0;
        for (int i = 7; i >= 0; i--) exp_data.push_back(8'(8'h80 + i));
        check_stream("backpressure");

        // ---- write collisions on alternate cycles ----
        do_reset();
        for (int i = 0; i < 6; i++) lifo_write(8'(8'h40 + i));
        clear_capture();
        popped.delete();
        wr_mode = 1;
        start_burst(5'd6);
        run_until_done(100);
        wr_mode = 0;
        lifo_wrreq_i = 1'b0;
        check("collide_pops", popped.size(), 32'd6);
        for (int i = 0; i < popped.size(); i++) exp_data.push_back(popped[i]);
        check_stream("collide");

        // ---- underrun stall ----
        do_reset();
        lifo_write(8'h01); lifo_write(8'h02);
        clear_capture();
        start_burst(5'd4);
        for (int i = 0; i < 10; i++) cyc();
        check("stall_words", got_data.size(), 32'd2);
        check("stall_busy", {31'd0, busy_o}, 32'd1);
        check("stall_no_done", {31'd0, done_seen}, 32'd0);
        lifo_write(8'hA5); lifo_write(8'h5A);
        run_until_done(40);
        exp_data = '{8'h02, 8'h01, 8'h5A, 8'hA5};
        check_stream("underrun");

        // ---- reset mid-burst ----
        do_reset();
        for (int i = 0; i < 8; i++) lifo_write(8'(8'h60 + i));
        clear_capture();
        rdy_mode = 2;
        start_burst(5'd8);
        cyc(); cyc(); cyc();
        check("midrst_buf_cnt", {30'd0, dut.r_buf_cnt}, 32'd2);
        check("midrst_inflight", {31'd0, dut.r_inflight}, 32'd1);
        srst_i = 1'b1;
        cyc();
        srst_i = 1'b0;
        check("midrst_valid", {31'd0, m_valid_o}, 32'd0);
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_rdreq", {31'd0, lifo_rdreq_o}, 32'd0);
        rdy_mode = 0;
        clear_capture();
        start_burst(5'd2);
        run_until_done(40);
        exp_data = '{8'h64, 8'h63};
        check_stream("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
